// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide engine for the EX stage. An accepted request
// spends exactly BITS cycles in CALC (one radix-2 step per cycle), one cycle in
// FIN for the sign fix-up, and the registered result/done appear the cycle
// after FIN. Every operation, special cases included, has the same latency.
//
// Ports
//   clk      in   1     clock, rising edge
//   rst      in   1     synchronous active-high reset
//   start    in   1     request, sampled only in IDLE
//   alu_ctrl in   5     ALUCtrl code (MUL..REMU accepted, anything else ignored)
//   op_a     in   BITS  rs1 operand (multiplicand / dividend)
//   op_b     in   BITS  rs2 operand (multiplier / divisor)
//   busy     out  1     high while an operation is in CALC or FIN
//   done     out  1     one-cycle pulse, result valid in that cycle
//   result   out  BITS  result of the last completed operation
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int BITS  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alu_ctrl,
    input  logic [BITS-1:0] op_a,
    input  logic [BITS-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] result
);

    localparam logic [4:0] ALUCTRL_MUL    = 5'd16;
    localparam logic [4:0] ALUCTRL_MULH   = 5'd17;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'd18;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'd19;
    localparam logic [4:0] ALUCTRL_DIV    = 5'd20;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'd21;
    localparam logic [4:0] ALUCTRL_REM    = 5'd22;
    localparam logic [4:0] ALUCTRL_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Two's-complement negation of a BITS-wide value when neg is set.
    function automatic logic [BITS-1:0] cond_neg(input logic [BITS-1:0] v, input logic neg);
        logic [BITS-1:0] r;
        if (neg) begin
            r = (~v) + {{(BITS-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negation of the double-width product when neg is set.
    function automatic logic [2*BITS-1:0] cond_neg2(input logic [2*BITS-1:0] v, input logic neg);
        logic [2*BITS-1:0] r;
        if (neg) begin
            r = (~v) + {{(2*BITS-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t              state_q,  state_d;
    logic [4:0]          op_q,     op_d;
    logic [BITS-1:0]     a_q,      a_d;       // raw dividend kept for REM by zero
    logic                b_zero_q, b_zero_d;
    logic                neg_a_q,  neg_a_d;
    logic                neg_b_q,  neg_b_d;
    logic [BITS-1:0]     mcand_q,  mcand_d;   // multiplicand or divisor magnitude
    logic [2*BITS-1:0]   prod_q,   prod_d;    // product; low half doubles as quotient shifter
    logic [BITS:0]       rem_q,    rem_d;     // partial remainder
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [BITS-1:0]     result_q, result_d;

    logic                accept_s;
    logic                sa_s, sb_s;
    logic [BITS-1:0]     mag_a_s, mag_b_s;
    logic [BITS:0]       mul_sum_s;
    logic [BITS:0]       div_shift_s;
    logic [BITS:0]       div_diff_s;
    logic [2*BITS-1:0]   prod_fix_s;

    // Next-state, datapath step and result fix-up.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_zero_d = b_zero_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;

        accept_s = start && (alu_ctrl >= ALUCTRL_MUL) && (alu_ctrl <= ALUCTRL_REMU);

        // Operand signedness per opcode.
        case (alu_ctrl)
            ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM: begin
                sa_s = op_a[BITS-1];
                sb_s = op_b[BITS-1];
            end
            ALUCTRL_MULHSU: begin
                sa_s = op_a[BITS-1];
                sb_s = 1'b0;
            end
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
        mag_a_s = cond_neg(op_a, sa_s);
        mag_b_s = cond_neg(op_b, sb_s);

        // Shift-add: add the multiplicand to the upper half when the current
        // multiplier LSB is set, then shift the whole product right by one.
        if (prod_q[0]) begin
            mul_sum_s = {1'b0, prod_q[2*BITS-1:BITS]} + {1'b0, mcand_q};
        end else begin
            mul_sum_s = {1'b0, prod_q[2*BITS-1:BITS]};
        end

        // Restoring divide: bring in the next dividend bit and trial-subtract.
        div_shift_s = {rem_q[BITS-1:0], prod_q[BITS-1]};
        div_diff_s  = div_shift_s - {1'b0, mcand_q};

        prod_fix_s = cond_neg2(prod_q, neg_a_q ^ neg_b_q);

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d     = alu_ctrl;
                    a_d      = op_a;
                    b_zero_d = (op_b == {BITS{1'b0}});
                    neg_a_d  = sa_s;
                    neg_b_d  = sb_s;
                    rem_d    = {(BITS+1){1'b0}};
                    cnt_d    = CNT_W'(BITS);
                    // Opcode bit 2 separates the divide group (20..23) from multiply (16..19).
                    if (alu_ctrl[2]) begin
                        mcand_d = mag_b_s;
                        prod_d  = {{BITS{1'b0}}, mag_a_s};
                    end else begin
                        mcand_d = mag_a_s;
                        prod_d  = {{BITS{1'b0}}, mag_b_s};
                    end
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (op_q[2]) begin
                    if (div_diff_s[BITS]) begin
                        rem_d  = div_shift_s;
                        prod_d = {prod_q[2*BITS-1:BITS], prod_q[BITS-2:0], 1'b0};
                    end else begin
                        rem_d  = div_diff_s;
                        prod_d = {prod_q[2*BITS-1:BITS], prod_q[BITS-2:0], 1'b1};
                    end
                end else begin
                    prod_d = {mul_sum_s, prod_q[BITS-1:1]};
                end
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                case (op_q)
                    ALUCTRL_MUL: result_d = prod_fix_s[BITS-1:0];
                    ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU:
                        result_d = prod_fix_s[2*BITS-1:BITS];
                    ALUCTRL_DIV, ALUCTRL_DIVU: begin
                        if (b_zero_q) begin
                            result_d = {BITS{1'b1}};
                        end else begin
                            result_d = cond_neg(prod_q[BITS-1:0], neg_a_q ^ neg_b_q);
                        end
                    end
                    ALUCTRL_REM, ALUCTRL_REMU: begin
                        // Remainder follows the dividend sign; divide by zero returns op_a.
                        if (b_zero_q) begin
                            result_d = a_q;
                        end else begin
                            result_d = cond_neg(rem_q[BITS-1:0], neg_a_q);
                        end
                    end
                    default: result_d = result_q;
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 5'd0;
            a_q      <= {BITS{1'b0}};
            b_zero_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mcand_q  <= {BITS{1'b0}};
            prod_q   <= {(2*BITS){1'b0}};
            rem_q    <= {(BITS+1){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {BITS{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_zero_q <= b_zero_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit (BITS=32): expected results are queued when
// a request is driven and compared whenever done pulses.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int BITS = 32;
    localparam int LAT  = 34;

    localparam logic [4:0] C_ADD    = 5'd0;
    localparam logic [4:0] C_MUL    = 5'd16;
    localparam logic [4:0] C_MULH   = 5'd17;
    localparam logic [4:0] C_MULHSU = 5'd18;
    localparam logic [4:0] C_MULHU  = 5'd19;
    localparam logic [4:0] C_DIV    = 5'd20;
    localparam logic [4:0] C_DIVU   = 5'd21;
    localparam logic [4:0] C_REM    = 5'd22;
    localparam logic [4:0] C_REMU   = 5'd23;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [4:0]      alu_ctrl;
    logic [BITS-1:0] op_a;
    logic [BITS-1:0] op_b;
    logic            busy;
    logic            done;
    logic [BITS-1:0] result;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [BITS-1:0] sb_q[$];
    string           tag_q[$];

    muldiv_unit #(.BITS(BITS), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference model of the eight RV32M operations.
    function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic signed [31:0] sa, sbv;
        logic [31:0] r;
        sa  = a;
        sbv = b;
        ea  = {32'd0, a};
        eb  = {32'd0, b};
        if (c == C_MULH || c == C_MULHSU) ea = {{32{a[31]}}, a};
        if (c == C_MULH) eb = {{32{b[31]}}, b};
        p = ea * eb;
        case (c)
            C_MUL:                     r = p[31:0];
            C_MULH, C_MULHSU, C_MULHU: r = p[63:32];
            C_DIV:  r = (b == 32'd0) ? 32'hFFFF_FFFF :
                        ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sbv));
            C_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            C_REM:  r = (b == 32'd0) ? a :
                        ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sbv));
            C_REMU: r = (b == 32'd0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                check_eq(tag_q.pop_front(), result, sb_q.pop_front());
            end
        end
    end

    // Count cycles from the accepting edge until done is seen; checks busy early.
    task automatic wait_done(input string tag, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (lat == 1) check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        start    = 1'b1;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        wait_done(tag, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(LAT));
    endtask

    initial begin
        int lat;
        int gap;
        bit seen;
        logic [4:0]  rc;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; alu_ctrl = 5'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",   {31'd0, busy}, 32'd0);
        check_eq("rst_done",   {31'd0, done}, 32'd0);
        check_eq("rst_result", result,        32'd0);
        rst = 1'b0;

        run_op("mul_7xm3",    C_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min",    C_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_max",   C_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_m1",   C_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2",    C_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem_m7_2",    C_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu_100_7",  C_DIVU,   32'd100,        32'd7,         32'd14);
        run_op("remu_100_7",  C_REMU,   32'd100,        32'd7,         32'd2);
        run_op("div_by0",     C_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op("remu_by0",    C_REMU,   32'd5,          32'd0,         32'd5);
        run_op("div_ovf",     C_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",     C_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            rc = 5'(16 + $urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 5 == 4) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            run_op($sformatf("rand%0d_op%0d", i, rc), rc, ra, rb, ref_model(rc, ra, rb));
        end

        // Non-muldiv code is ignored.
        @(negedge clk);
        alu_ctrl = C_ADD; op_a = 32'd1; op_b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("add_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check_eq("add_busy_late", {31'd0, busy}, 32'd0);

        // Reset mid-operation: no done, result cleared, engine reusable.
        @(negedge clk);
        alu_ctrl = C_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        op_a = 32'd77; op_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy",   {31'd0, busy}, 32'd0);
        check_eq("midrst_result", result,        32'd0);
        repeat (50) @(negedge clk);
        run_op("mul_3x4", C_MUL, 32'd3, 32'd4, 32'd12);

        // Back-to-back with start held high; operands change while busy.
        @(negedge clk);
        alu_ctrl = C_DIVU; op_a = 32'd1000; op_b = 32'd9; start = 1'b1;
        sb_q.push_back(32'd111);  tag_q.push_back("b2b_first");
        sb_q.push_back(32'd4141); tag_q.push_back("b2b_second");
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                alu_ctrl = C_MULU_SEL(); op_a = 32'd101; op_b = 32'd41;
            end
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) check_eq("b2b_first_timeout", 32'd0, 32'd1);
        check_eq("b2b_first_lat", 32'(lat), 32'(LAT));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        gap  = 1;
        if (done === 1'b1) seen = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            gap++;
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) check_eq("b2b_second_timeout", 32'd0, 32'd1);
        check_eq("b2b_gap", 32'(gap), 32'(LAT));

        repeat (40) @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    // Opcode used for the second back-to-back request.
    function automatic logic [4:0] C_MULU_SEL();
        return C_MUL;
    endfunction

endmodule
